phy_rx_lanes: RTL and testbench
===============================

# phy_rx_lanes

Parametrised single-clock receive PHY. Recovers byte alignment from a bit-serial input by hunting for the COM symbol, declares the link active after a programmable run of consecutive COMs, and distributes data bytes round-robin across `LANES` parallel output lanes. Runs a bit-serial return stream toward the transmitter: COM while not active, IDLE once active. Replaces the multi-clock serial-parallel, demux and idle-serializer chain with one block clocked at bit rate, using internal counters instead of divided clocks.

## Interface
Parameters:
- `LANES`, 4: number of output lanes, ≥2, power of two.
- `WIDTH`, 8: symbol width in bits.
- `COM_SYM`, 8'hBC: alignment/comma symbol.
- `IDLE_SYM`, 8'h7C: symbol sent back while active.
- `COM_CNT`, 4: consecutive COMs needed to go active, 1..15.
- `MAX_GAP`, 64: maximum number of words allowed between COMs while active (used only when loss detection is built in).

Ports:
- `clk32f`, in, 1: bit clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `in`, in, 1: serial data, MSB first.
- `out_data`, out, LANES*WIDTH: lane k occupies bits [k*WIDTH +: WIDTH].
- `out_valid`, out, LANES: one-cycle pulse per lane when that lane is written.
- `out_frame`, out, 1: one-cycle pulse when lane LANES-1 is written.
- `active`, out, 1: link active.
- `locked`, out, 1: byte boundary found (state SYNC or ACTIVE).
- `out_rx_tx`, out, 1: serial return stream, MSB first.

## Operation
- Shift register: `sh <= {sh[WIDTH-2:0], in}` every cycle. The candidate word is `{sh[WIDTH-2:0], in}`.
- `bitcnt` counts 0..WIDTH-1 in SYNC and ACTIVE. A word completes when `bitcnt == WIDTH-1`. In HUNT, the candidate word is compared against COM on every cycle.
- States:
  - HUNT: on a candidate equal to COM_SYM, go to SYNC, set `bitcnt`=0 and `comcnt`=1. If COM_CNT=1, go directly to ACTIVE.
  - SYNC: on each completed word:
    - COM: increment `comcnt`. Reaching COM_CNT goes to ACTIVE.
    - Non-COM: return to HUNT and clear `comcnt`.
  - ACTIVE: on each completed word:
    - COM: not forwarded. Resets `lane_ptr` to 0.
    - Other word: written to lane `lane_ptr`. Pulse `out_valid[lane_ptr]`, then `lane_ptr` increments modulo LANES (wraps from LANES-1 to 0).
- A COM arriving mid-group truncates the group. No `out_frame` pulse is produced for a truncated group, and lanes not yet written keep their old data.
- Return serializer: a free-running WIDTH-bit counter, independent of receive alignment. It reloads at each word boundary with IDLE_SYM if `active` is high at that edge, otherwise COM_SYM. The mode changes only on a serializer word boundary, never mid-symbol.
- Reset (asserted `reset`=0):
  - Outputs: all go to 0, including `out_rx_tx`.
  - Internal: state HUNT; `bitcnt`, `comcnt` and `lane_ptr` all 0.
  - Serializer: the first symbol after release is COM_SYM.
- Reset mid-operation: immediately discards any partial word and partial lane group.

## Timing
- Lane register and `out_valid` update on the same edge that samples the last bit of a word. This is 0 extra cycles of latency after that edge, and the data is visible for the following cycle.
- `out_data` holds until the lane is rewritten.
- `active` rises on the edge sampling the last bit of the COM_CNT-th COM. A data word immediately following that COM is forwarded.
- Steady state: one `out_valid` pulse per WIDTH cycles.
- `out_rx_tx` changes only on clock edges. It switches to IDLE at the first serializer boundary after `active` rises (0..WIDTH-1 cycles later).

## Configuration
- `PHY_RX_LOSS_DET_EN` defined:
  - In ACTIVE, a gap counter counts completed words since the last COM.
  - When the count exceeds MAX_GAP, the state returns to HUNT: `active`, `locked` and `lane_ptr` go to 0, and the word that overflowed is not forwarded.
- `PHY_RX_LOSS_DET_EN` undefined: ACTIVE is left only by reset, and the gap counter is not built.

## Structure
- Shared package: state encoding (HUNT/SYNC/ACTIVE), default COM_SYM/IDLE_SYM constants, and `clog2`-based width helpers for `lane_ptr`/`comcnt`.
- One sub-module, `phy_rx_idle_ser`: the free-running return serializer. Inputs are `active`, `clk32f` and `reset`; output is `out_rx_tx`.
- Alignment FSM and lane distribution stay in the top level.

## Test plan
- Reset held low for 3 cycles mid-stream: every output reads 0. After release, the first 8 `out_rx_tx` bits are 1011_1100.
- Stream 3 random bits, then 4×8'hBC, then 8'h11, 22, 33, 44 (defaults): `active`=1 after the 4th COM. Lanes 0..3 read 11, 22, 33, 44, each with a one-cycle `out_valid`, and `out_frame` pulses with lane 3.
- 2×COM, 8'h55, then 4×COM: state is HUNT after 8'h55 and `active` stays 0 until the later run completes. No `out_valid` pulses occur.
- While active: 8'hA1, A2, COM, A3: lanes 0, 1, 0 receive A1, A2, A3. No `out_frame` pulse occurs and lane 2/3 data is unchanged.
- Check the `out_rx_tx` mode switch: it moves from 8'hBC to 8'h7C only on a serializer word boundary after `active` rises, never with a mixed symbol.
- With `PHY_RX_LOSS_DET_EN`, MAX_GAP=4: after going active, send 5 data words with no COM. `active` falls on the 5th word, which is not forwarded.

Source files
------------

// File: rtl/phy_rx_lanes_pkg.sv
// phy_rx_lanes_pkg
//   Shared definitions for the receive PHY slice:
//   - rx_state_e   : alignment FSM encoding (HUNT / SYNC / ACTIVE)
//   - DEF_COM_SYM  : default comma / alignment symbol
//   - DEF_IDLE_SYM : default symbol returned while the link is active
//   - ptr_w/cnt_w  : width helpers for lane pointer and run/gap counters
package phy_rx_lanes_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } rx_state_e;

  localparam logic [7:0] DEF_COM_SYM  = 8'hBC;
  localparam logic [7:0] DEF_IDLE_SYM = 8'h7C;

  // Width of an index selecting one of n items (at least 1 bit).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_cnt inclusive.
  function automatic int cnt_w(input int max_cnt);
    return (max_cnt > 0) ? $clog2(max_cnt + 1) : 1;
  endfunction

endpackage

// File: rtl/phy_rx_lanes_if.sv
// phy_rx_lanes_if
//   Parallel-side bundle of the receive PHY.
//   out_data  : LANES*WIDTH lane registers, lane k at [k*WIDTH +: WIDTH]
//   out_valid : per-lane one-cycle write pulse
//   out_frame : one-cycle pulse when the last lane is written
//   active    : link active
//   locked    : byte boundary found (SYNC or ACTIVE)
//   master modport drives the bundle (PHY side), slave modport observes it.
interface phy_rx_lanes_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
);
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_valid;
  logic                   out_frame;
  logic                   active;
  logic                   locked;

  modport master (output out_data, output out_valid, output out_frame,
                  output active, output locked);
  modport slave  (input out_data, input out_valid, input out_frame,
                  input active, input locked);
endinterface

// File: rtl/phy_rx_idle_ser.sv
// phy_rx_idle_ser
//   Free-running return serializer. Emits COM_SYM while the link is not
//   active and IDLE_SYM once it is, MSB first, one bit per clk32f cycle.
//   The symbol choice is sampled only at its own word boundary, so a
//   symbol is never mixed. Its framing is independent of receive alignment.
//   Ports: clk32f (bit clock), reset (async, active-low), active (link
//   state), out_rx_tx (registered serial output, 0 in reset).
module phy_rx_idle_ser
  import phy_rx_lanes_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] COM_SYM  = WIDTH'(DEF_COM_SYM),
  parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'(DEF_IDLE_SYM)
) (
  input  logic clk32f,
  input  logic reset,
  input  logic active,
  output logic out_rx_tx
);
  localparam int BW = ptr_w(WIDTH);

  logic [BW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic [WIDTH-1:0] word;

  always_comb begin
    word    = active ? IDLE_SYM : COM_SYM;
    cnt_d   = (cnt_q == BW'(WIDTH - 1)) ? '0 : cnt_q + 1'b1;
    // Count 0 is the boundary: launch the MSB and park the rest.
    if (cnt_q == '0) begin
      tx_d    = word[WIDTH-1];
      shreg_d = word[WIDTH-2:0];
    end else begin
      tx_d    = shreg_q[WIDTH-2];
      shreg_d = {shreg_q[WIDTH-3:0], 1'b0};
    end
  end

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign out_rx_tx = tx_q;
endmodule

// File: rtl/phy_rx_lanes.sv
// phy_rx_lanes
//   Bit-rate receive PHY: hunts for COM on every bit, confirms alignment
//   with COM_CNT consecutive COMs, then distributes data words round-robin
//   over LANES lane registers. COM while active restarts the lane group.
//   Optional macro PHY_RX_LOSS_DET_EN: drop back to HUNT when more than
//   MAX_GAP data words arrive without a COM.
//   Ports: clk32f (bit clock), reset (async, active-low), in (serial data,
//   MSB first), out_rx_tx (return stream), rx (parallel bundle, master).
module phy_rx_lanes
  import phy_rx_lanes_pkg::*;
#(
  parameter int               LANES    = 4,
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] COM_SYM  = WIDTH'(DEF_COM_SYM),
  parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'(DEF_IDLE_SYM),
  parameter int               COM_CNT  = 4,
  parameter int               MAX_GAP  = 64
) (
  input  logic           clk32f,
  input  logic           reset,
  input  logic           in,
  output logic           out_rx_tx,
  phy_rx_lanes_if.master rx
);
  localparam int LPW = ptr_w(LANES);
  localparam int BW  = ptr_w(WIDTH);
  localparam int CW  = cnt_w(COM_CNT);

  if (LANES < 2 || (LANES & (LANES - 1)) != 0 || WIDTH < 3 ||
      COM_CNT < 1 || COM_CNT > 15 || MAX_GAP < 1) begin : g_param_err
    $error("phy_rx_lanes: illegal parameter set");
  end

  rx_state_e        state_q, state_d;
  logic [WIDTH-2:0] sh_q;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [CW-1:0]    comcnt_q, comcnt_d;
  logic [LPW-1:0]   lane_ptr_q, lane_ptr_d;
  logic             frame_q, frame_d;
  logic [WIDTH-1:0] cand;
  logic             is_com, word_done, wr_en, gap_over;
  logic             active_o, locked_o;

  // The word that ends on this edge includes the bit being sampled now.
  assign cand      = {sh_q, in};
  assign is_com    = (cand == COM_SYM);
  assign word_done = (bitcnt_q == BW'(WIDTH - 1));

`ifdef PHY_RX_LOSS_DET_EN
  localparam int GW = cnt_w(MAX_GAP);
  logic [GW-1:0] gap_q, gap_d;

  assign gap_over = (gap_q >= GW'(MAX_GAP));

  always_comb begin
    gap_d = gap_q;
    if (state_q != ST_ACTIVE) begin
      gap_d = '0;
    end else if (word_done) begin
      gap_d = (is_com || gap_over) ? '0 : gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`else
  assign gap_over = 1'b0;
`endif

  // State register and receive datapath registers.
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HUNT;
      sh_q       <= '0;
      bitcnt_q   <= '0;
      comcnt_q   <= '0;
      lane_ptr_q <= '0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= cand[WIDTH-2:0];
      bitcnt_q   <= bitcnt_d;
      comcnt_q   <= comcnt_d;
      lane_ptr_q <= lane_ptr_d;
      frame_q    <= frame_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    comcnt_d   = comcnt_q;
    lane_ptr_d = lane_ptr_q;
    wr_en      = 1'b0;
    unique case (state_q)
      ST_HUNT: begin
        bitcnt_d   = '0;
        lane_ptr_d = '0;
        if (is_com) begin
          comcnt_d = CW'(1);
          state_d  = (COM_CNT == 1) ? ST_ACTIVE : ST_SYNC;
        end
      end
      ST_SYNC: begin
        bitcnt_d = word_done ? '0 : bitcnt_q + 1'b1;
        if (word_done) begin
          if (is_com) begin
            comcnt_d = comcnt_q + 1'b1;
            if (comcnt_q + 1'b1 == CW'(COM_CNT)) state_d = ST_ACTIVE;
          end else begin
            state_d  = ST_HUNT;
            comcnt_d = '0;
          end
        end
      end
      ST_ACTIVE: begin
        bitcnt_d = word_done ? '0 : bitcnt_q + 1'b1;
        if (word_done) begin
          if (is_com) begin
            lane_ptr_d = '0;
          end else if (gap_over) begin
            // Overflowing word is dropped together with the alignment.
            state_d    = ST_HUNT;
            lane_ptr_d = '0;
            comcnt_d   = '0;
            bitcnt_d   = '0;
          end else begin
            wr_en      = 1'b1;
            lane_ptr_d = lane_ptr_q + 1'b1;  // LANES is a power of two
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // Output decode.
  always_comb begin
    active_o = (state_q == ST_ACTIVE);
    locked_o = (state_q != ST_HUNT);
    frame_d  = wr_en && (lane_ptr_q == LPW'(LANES - 1));
  end

  // Per-lane data register and valid pulse.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic             lane_wr;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q;

    assign lane_wr = wr_en && (lane_ptr_q == LPW'(gi));

    always_comb begin
      data_d = lane_wr ? cand : data_q;
    end

    always_ff @(posedge clk32f or negedge reset) begin
      if (!reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= lane_wr;
      end
    end

    assign rx.out_data[gi*WIDTH +: WIDTH] = data_q;
    assign rx.out_valid[gi]               = valid_q;
  end

  assign rx.out_frame = frame_q;
  assign rx.active    = active_o;
  assign rx.locked    = locked_o;

  phy_rx_idle_ser #(
    .WIDTH    (WIDTH),
    .COM_SYM  (COM_SYM),
    .IDLE_SYM (IDLE_SYM)
  ) u_idle_ser (
    .clk32f    (clk32f),
    .reset     (reset),
    .active    (active_o),
    .out_rx_tx (out_rx_tx)
  );
endmodule

// File: tb/tb_phy_rx_lanes.sv
// tb_phy_rx_lanes
//   Directed + randomized stimulus for phy_rx_lanes, checked every bit
//   against a behavioural model of the link (bit history, word count since
//   alignment, lane array, serializer symbol schedule).
//   Build with PHY_RX_LOSS_DET_EN defined to also exercise loss detection
//   (MAX_GAP = 4 in that build).
module tb_phy_rx_lanes;
  localparam int         LANES   = 4;
  localparam int         W       = 8;
  localparam logic [7:0] COM     = 8'hBC;
  localparam logic [7:0] IDLE    = 8'h7C;
  localparam int         COM_CNT = 4;
`ifdef PHY_RX_LOSS_DET_EN
  localparam int MAX_GAP = 4;
  localparam bit LOSS    = 1'b1;
`else
  localparam int MAX_GAP = 64;
  localparam bit LOSS    = 1'b0;
`endif

  logic clk32f = 1'b0;
  logic reset  = 1'b1;
  logic din    = 1'b0;
  logic out_rx_tx;

  phy_rx_lanes_if #(.LANES(LANES), .WIDTH(W)) rx_if ();

  phy_rx_lanes #(
    .LANES(LANES), .WIDTH(W), .COM_SYM(COM), .IDLE_SYM(IDLE),
    .COM_CNT(COM_CNT), .MAX_GAP(MAX_GAP)
  ) dut (
    .clk32f    (clk32f),
    .reset     (reset),
    .in        (din),
    .out_rx_tx (out_rx_tx),
    .rx        (rx_if)
  );

  always #5 clk32f = ~clk32f;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [W-1:0] hist;
  bit           m_aligned, m_active;
  int           m_run, m_nbits, m_ptr, m_gap;
  logic [W-1:0] m_lane [LANES];
  int           ser_cnt;
  logic [W-1:0] ser_sym, obs_sym, prev_sym;
  bit           first_sym_pending, saw_switch;
  int           valid_pulses, frame_pulses;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = '0; m_aligned = 0; m_active = 0; m_run = 0; m_nbits = 0;
    m_ptr = 0; m_gap = 0; ser_cnt = 0; obs_sym = '0;
    first_sym_pending = 1;
    for (int k = 0; k < LANES; k++) m_lane[k] = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {rx_if.out_data, rx_if.out_valid, rx_if.out_frame,
              rx_if.active, rx_if.locked, out_rx_tx}, 64'd0);
  endtask

  // Called at posedge+1; holds reset low for n edges, releases at posedge+1.
  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    chk_all_zero("reset_async");
    repeat (n) begin
      @(posedge clk32f); #1;
      chk_all_zero("reset_hold");
    end
    model_reset();
    reset = 1'b1;
  endtask

  // One bit time: drive, clock, advance the model, compare.
  task automatic step(input logic b);
    logic [LANES-1:0]   ev;
    logic               ef;
    logic [LANES*W-1:0] ed;
    bit                 prev_act;
    int                 idx;
    din = b;
    @(posedge clk32f); #1;
    ev = '0; ef = 1'b0;
    prev_act = m_active;
    hist = {hist[W-2:0], b};
    if (!m_aligned) begin
      if (hist == COM) begin
        m_aligned = 1; m_run = 1; m_nbits = 0; m_ptr = 0; m_gap = 0;
        m_active  = (COM_CNT == 1);
      end
    end else begin
      m_nbits++;
      if (m_nbits % W == 0) begin
        if (!m_active) begin
          if (hist == COM) begin
            m_run++;
            if (m_run >= COM_CNT) begin m_active = 1; m_gap = 0; m_ptr = 0; end
          end else begin
            m_aligned = 0; m_run = 0;
          end
        end else if (hist == COM) begin
          m_ptr = 0; m_gap = 0;
        end else if (LOSS && (m_gap + 1 > MAX_GAP)) begin
          m_aligned = 0; m_active = 0; m_run = 0; m_ptr = 0; m_gap = 0;
        end else begin
          m_gap++;
          m_lane[m_ptr] = hist;
          ev[m_ptr] = 1'b1;
          ef = (m_ptr == LANES - 1);
          m_ptr = (m_ptr + 1) % LANES;
        end
      end
    end
    for (int k = 0; k < LANES; k++) ed[k*W +: W] = m_lane[k];

    chk("active", rx_if.active, m_active);
    chk("locked", rx_if.locked, m_aligned);
    chk("out_valid", rx_if.out_valid, ev);
    chk("out_frame", rx_if.out_frame, ef);
    chk("out_data", rx_if.out_data, ed);
    valid_pulses += $countones(rx_if.out_valid);
    frame_pulses += int'(rx_if.out_frame);

    // Return stream: symbol chosen by link state at each serializer boundary.
    idx = ser_cnt % W;
    if (idx == 0) ser_sym = prev_act ? IDLE : COM;
    obs_sym = {obs_sym[W-2:0], out_rx_tx};
    if (idx == W - 1) begin
      chk("tx_symbol", obs_sym, ser_sym);
      if (first_sym_pending) begin
        chk("tx_first_after_reset", obs_sym, 64'hBC);
        first_sym_pending = 0;
      end
      if (prev_sym == COM && obs_sym == IDLE) saw_switch = 1;
      prev_sym = obs_sym;
    end
    ser_cnt++;
  endtask

  task automatic send_byte(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) step(v[i]);
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] v;
    do v = W'($urandom_range(0, 255)); while (v == COM);
    return v;
  endfunction

  initial begin
    logic [W-1:0] l2, l3;
    int since_com;
    prev_sym = '0; saw_switch = 0; valid_pulses = 0; frame_pulses = 0;
    model_reset();
    #2;
    do_reset(3);

    // Random lead-in, alignment run and first lane group.
    repeat (3) step(1'($urandom_range(0, 1)));
    for (int i = 0; i < COM_CNT; i++) begin
      send_byte(COM);
      chk("active_during_run", rx_if.active, (i == COM_CNT - 1));
    end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("frame_with_lane3", {rx_if.out_frame, rx_if.out_valid}, 5'b11000);
    chk("lanes_11_44", rx_if.out_data, 32'h44332211);

    // Random groups with a COM ahead of every group of four.
    repeat (3) begin
      send_byte(COM);
      repeat (LANES) send_byte(rand_data());
    end

    // Truncated group: A1, A2, COM, A3.
    send_byte(COM);
    l2 = m_lane[2]; l3 = m_lane[3];
    frame_pulses = 0;
    send_byte(8'hA1); send_byte(8'hA2); send_byte(COM); send_byte(8'hA3);
    chk("trunc_lane0", rx_if.out_data[0 +: W], 8'hA3);
    chk("trunc_lane1", rx_if.out_data[W +: W], 8'hA2);
    chk("trunc_lane2_kept", rx_if.out_data[2*W +: W], l2);
    chk("trunc_lane3_kept", rx_if.out_data[3*W +: W], l3);
    chk("trunc_no_frame", frame_pulses, 0);

    // Mid-stream reset, partway into a word.
    repeat (3) step(1'($urandom_range(0, 1)));
    do_reset(3);

    // Broken run: 2 COM, 0x55, then a full run.
    valid_pulses = 0;
    send_byte(COM); send_byte(COM);
    chk("locked_after_2com", rx_if.locked, 1);
    send_byte(8'h55);
    chk("hunt_after_55", {rx_if.locked, rx_if.active}, 2'b00);
    for (int i = 0; i < COM_CNT; i++) begin
      send_byte(COM);
      chk("active_rerun", rx_if.active, (i == COM_CNT - 1));
    end
    chk("no_valid_in_run", valid_pulses, 0);

    // Random traffic, COM at random and at least every 4 data words.
    since_com = 0;
    for (int i = 0; i < 40; i++) begin
      if (since_com == 4 || $urandom_range(0, 4) == 0) begin
        send_byte(COM); since_com = 0;
      end else begin
        send_byte(rand_data()); since_com++;
      end
    end

`ifdef PHY_RX_LOSS_DET_EN
    repeat (COM_CNT) send_byte(COM);
    chk("loss_active_start", rx_if.active, 1);
    valid_pulses = 0;
    repeat (MAX_GAP) send_byte(rand_data());
    chk("loss_active_at_max", rx_if.active, 1);
    chk("loss_valid_at_max", valid_pulses, MAX_GAP);
    send_byte(rand_data());
    chk("loss_active_fall", {rx_if.active, rx_if.locked}, 2'b00);
    chk("loss_word_dropped", valid_pulses, MAX_GAP);
`endif

    repeat (2 * W) step(1'b0);
    chk("tx_mode_switch_seen", saw_switch, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
